scariv_missu_ctrl: RTL and testbench

- L1 data-cache miss unit (MISSU) controller for the scariv core; sits between the LSU pipes, the L2/bus request and response channels, and the DCache refill write port.
- Tracks up to MISSU_ENTRY_SIZE outstanding line misses. Merges same-line misses into one entry.
- Schedules L2 requests and DCache refills with round-robin arbitration. Pulses a per-entry wakeup so the LSU replays waiting loads and stores.

---
 rtl/scariv_missu_pkg.sv | 36 +++
 rtl/scariv_missu_rr_arb.sv | 59 +++++
 rtl/scariv_missu_ctrl.sv | 164 ++++++++++++++++
 tb/tb_scariv_missu_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scariv_missu_pkg.sv
// scariv L1D miss unit: shared types and sizing.
// Entry lifecycle enum, per-entry storage and line helpers.
package scariv_missu_pkg;

  localparam int ENTRY_SIZE = 2;
  localparam int PADDR_W    = 56;
  localparam int LINE_W     = 128;

  function automatic int ofs_w(input int lw);
    return $clog2(lw / 8);
  endfunction

  localparam int OFS_W   = ofs_w(LINE_W);
  localparam int ID_W    = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1;
  localparam int LADDR_W = PADDR_W - OFS_W;

  typedef enum logic [1:0] {
    INVALID,
    ISSUE_WAIT,
    RESP_WAIT,
    REFILL
  } missu_state_t;

  typedef struct packed {
    missu_state_t        state;
    logic [LADDR_W-1:0]  line;
    logic [LINE_W-1:0]   data;
  } missu_entry_t;

  function automatic logic [LADDR_W-1:0] line_of(
    input logic [PADDR_W-1:0] pa
  );
    return pa[PADDR_W-1:OFS_W];
  endfunction

endpackage

// File: rtl/scariv_missu_rr_arb.sv
// Round-robin arbiter with grant lock.
// A shown grant is held until acknowledged.
module scariv_missu_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_ack,
  output logic          o_valid,
  output logic [IW-1:0] o_id
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_lock_id;
  logic          r_lock;
  logic [IW-1:0] w_pick;
  logic          w_found;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] ptr,
    input int            k
  );
    int s;
    s = int'(ptr) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[rr_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = rr_idx(r_ptr, k);
      end
    end
  end

  assign o_valid = |i_req;
  assign o_id    = r_lock ? r_lock_id : w_pick;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (o_valid && i_ack) begin
      r_lock <= 1'b0;
      r_ptr  <= rr_idx(o_id, 1);
    end else if (o_valid) begin
      r_lock    <= 1'b1;
      r_lock_id <= o_id;
    end
  end

endmodule

// File: rtl/scariv_missu_ctrl.sv
// scariv L1D miss unit controller: allocate/merge misses,
// issue L2 line reads, refill DCache and wake the LSU.
module scariv_missu_ctrl
  import scariv_missu_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_miss_valid,
  input  logic [PADDR_W-1:0]    i_miss_paddr,
  output logic                  o_miss_ready,
  output logic [ID_W-1:0]       o_miss_id,
  output logic                  o_l2_req_valid,
  output logic [PADDR_W-1:0]    o_l2_req_paddr,
  output logic [ID_W-1:0]       o_l2_req_tag,
  input  logic                  i_l2_req_ready,
  input  logic                  i_l2_resp_valid,
  input  logic [ID_W-1:0]       i_l2_resp_tag,
  input  logic [LINE_W-1:0]     i_l2_resp_data,
  output logic                  o_refill_valid,
  output logic [PADDR_W-1:0]    o_refill_paddr,
  output logic [LINE_W-1:0]     o_refill_data,
  input  logic                  i_refill_ready,
  output logic                  o_wakeup_valid,
  output logic [ID_W-1:0]       o_wakeup_id,
  output logic [ENTRY_SIZE-1:0] o_busy_vec
);

  missu_entry_t          r_entry [ENTRY_SIZE];
  logic [ENTRY_SIZE-1:0] r_stale_ok;
  logic                  r_wakeup_valid;
  logic [ID_W-1:0]       r_wakeup_id;

  logic [ENTRY_SIZE-1:0] w_issue_req;
  logic [ENTRY_SIZE-1:0] w_refill_req;
  logic                  w_hit_any;
  logic                  w_free_any;
  logic [ID_W-1:0]       w_hit_id;
  logic [ID_W-1:0]       w_free_id;
  logic                  w_l2_valid;
  logic [ID_W-1:0]       w_l2_id;
  logic                  w_rf_valid;
  logic [ID_W-1:0]       w_rf_id;
  logic                  w_l2_hs;
  logic                  w_rf_hs;
  logic                  w_hit_blocked;
  logic                  w_alloc;
  logic                  w_resp_bad;
  logic                  w_unused;

  assign w_unused = ^i_miss_paddr[OFS_W-1:0];

  always_comb begin
    w_issue_req  = '0;
    w_refill_req = '0;
    o_busy_vec   = '0;
    w_hit_any    = 1'b0;
    w_hit_id     = '0;
    w_free_any   = 1'b0;
    w_free_id    = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      w_issue_req[i]  = r_entry[i].state == ISSUE_WAIT;
      w_refill_req[i] = r_entry[i].state == REFILL;
      o_busy_vec[i]   = r_entry[i].state != INVALID;
      if (o_busy_vec[i] &&
          r_entry[i].line == line_of(i_miss_paddr)) begin
        w_hit_any = 1'b1;
        w_hit_id  = ID_W'(i);
      end
    end
    for (int i = ENTRY_SIZE - 1; i >= 0; i--) begin
      if (r_entry[i].state == INVALID) begin
        w_free_any = 1'b1;
        w_free_id  = ID_W'(i);
      end
    end
  end

  scariv_missu_rr_arb #(.N(ENTRY_SIZE), .IW(ID_W)) u_l2_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (w_issue_req),
    .i_ack     (i_l2_req_ready),
    .o_valid   (w_l2_valid),
    .o_id      (w_l2_id)
  );

  // Refill requests come only from registered entry state.
  scariv_missu_rr_arb #(.N(ENTRY_SIZE), .IW(ID_W)) u_rf_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (w_refill_req),
    .i_ack     (i_refill_ready),
    .o_valid   (w_rf_valid),
    .o_id      (w_rf_id)
  );

  assign w_l2_hs       = w_l2_valid & i_l2_req_ready;
  assign w_rf_hs       = w_rf_valid & i_refill_ready;
  assign w_hit_blocked = w_rf_hs & (w_rf_id == w_hit_id);
  assign w_alloc       = i_miss_valid & ~w_hit_any & w_free_any;

  assign o_miss_ready = i_miss_valid &
                        (w_hit_any ? ~w_hit_blocked : w_free_any);
  assign o_miss_id    = !o_miss_ready ? '0 :
                        w_hit_any ? w_hit_id : w_free_id;

  assign o_l2_req_valid = w_l2_valid;
  assign o_l2_req_tag   = w_l2_valid ? w_l2_id : '0;
  assign o_l2_req_paddr = !w_l2_valid ? '0 :
                          {r_entry[w_l2_id].line, {OFS_W{1'b0}}};

  assign o_refill_valid = w_rf_valid;
  assign o_refill_paddr = !w_rf_valid ? '0 :
                          {r_entry[w_rf_id].line, {OFS_W{1'b0}}};
  assign o_refill_data  = w_rf_valid ? r_entry[w_rf_id].data : '0;

  assign o_wakeup_valid = r_wakeup_valid;
  assign o_wakeup_id    = r_wakeup_id;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ENTRY_SIZE; i++) r_entry[i] <= '0;
      r_stale_ok <= '1;
    end else begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        if (w_alloc && w_free_id == ID_W'(i)) begin
          r_entry[i].state <= ISSUE_WAIT;
          r_entry[i].line  <= line_of(i_miss_paddr);
          r_stale_ok[i]    <= 1'b0;
        end
        if (w_l2_hs && w_l2_id == ID_W'(i))
          r_entry[i].state <= RESP_WAIT;
        if (i_l2_resp_valid && i_l2_resp_tag == ID_W'(i) &&
            r_entry[i].state == RESP_WAIT) begin
          r_entry[i].state <= REFILL;
          r_entry[i].data  <= i_l2_resp_data;
        end
        if (w_rf_hs && w_rf_id == ID_W'(i))
          r_entry[i].state <= INVALID;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wakeup_valid <= 1'b0;
      r_wakeup_id    <= '0;
    end else begin
      r_wakeup_valid <= w_rf_hs;
      if (w_rf_hs) r_wakeup_id <= w_rf_id;
    end
  end

  // Stale responses to entries untouched since reset are tolerated.
  assign w_resp_bad = i_l2_resp_valid &&
    r_entry[i_l2_resp_tag].state != RESP_WAIT &&
    !(r_entry[i_l2_resp_tag].state == INVALID &&
      r_stale_ok[i_l2_resp_tag]);

  a_resp_legal: assert property (
    @(posedge i_clk) disable iff (!i_reset_n) !w_resp_bad
  );

endmodule

// File: tb/tb_scariv_missu_ctrl.sv
// Testbench for scariv_missu_ctrl: directed scenarios plus
// randomized traffic against a behavioural miss-unit model.
module tb_scariv_missu_ctrl;

  localparam int PW = 56;
  localparam int LW = 128;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_miss_valid;
  logic [PW-1:0] i_miss_paddr;
  logic          o_miss_ready;
  logic [0:0]    o_miss_id;
  logic          o_l2_req_valid;
  logic [PW-1:0] o_l2_req_paddr;
  logic [0:0]    o_l2_req_tag;
  logic          i_l2_req_ready;
  logic          i_l2_resp_valid;
  logic [0:0]    i_l2_resp_tag;
  logic [LW-1:0] i_l2_resp_data;
  logic          o_refill_valid;
  logic [PW-1:0] o_refill_paddr;
  logic [LW-1:0] o_refill_data;
  logic          i_refill_ready;
  logic          o_wakeup_valid;
  logic [0:0]    o_wakeup_id;
  logic [1:0]    o_busy_vec;

  scariv_missu_ctrl dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_miss_valid    (i_miss_valid),
    .i_miss_paddr    (i_miss_paddr),
    .o_miss_ready    (o_miss_ready),
    .o_miss_id       (o_miss_id),
    .o_l2_req_valid  (o_l2_req_valid),
    .o_l2_req_paddr  (o_l2_req_paddr),
    .o_l2_req_tag    (o_l2_req_tag),
    .i_l2_req_ready  (i_l2_req_ready),
    .i_l2_resp_valid (i_l2_resp_valid),
    .i_l2_resp_tag   (i_l2_resp_tag),
    .i_l2_resp_data  (i_l2_resp_data),
    .o_refill_valid  (o_refill_valid),
    .o_refill_paddr  (o_refill_paddr),
    .o_refill_data   (o_refill_data),
    .i_refill_ready  (i_refill_ready),
    .o_wakeup_valid  (o_wakeup_valid),
    .o_wakeup_id     (o_wakeup_id),
    .o_busy_vec      (o_busy_vec)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Model: 0 free, 1 needs L2 read, 2 awaiting data, 3 needs refill
  int          m_st [2];
  logic [51:0] m_line [2];
  logic [127:0] m_data [2];
  int m_l2_ptr, m_l2_cur, m_rf_ptr, m_rf_cur;
  bit m_wk;
  int m_wk_id;

  bit e_rdy, e_l2v, e_rfv;
  int e_id, e_l2id, e_rfid, e_hit, e_free;

  logic [127:0] d0, d1, d2;

  task automatic ck(input string tag, input logic [127:0] obs,
                    input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0;
      m_line[i] = '0;
      m_data[i] = '0;
    end
    m_l2_ptr = 0; m_l2_cur = -1;
    m_rf_ptr = 0; m_rf_cur = -1;
    m_wk = 0; m_wk_id = 0;
  endtask

  function automatic int pick(input int cur, input int ptr,
                              input int want);
    if (cur >= 0) return cur;
    for (int k = 0; k < 2; k++)
      if (m_st[(ptr + k) % 2] == want) return (ptr + k) % 2;
    return -1;
  endfunction

  task automatic chk();
    logic [1:0] busy;
    #1;
    e_l2id = pick(m_l2_cur, m_l2_ptr, 1);
    e_l2v  = e_l2id >= 0;
    e_rfid = pick(m_rf_cur, m_rf_ptr, 3);
    e_rfv  = e_rfid >= 0;
    e_hit = -1;
    e_free = -1;
    busy = '0;
    for (int i = 1; i >= 0; i--) begin
      busy[i] = m_st[i] != 0;
      if (m_st[i] != 0 && m_line[i] == i_miss_paddr[55:4]) e_hit = i;
      if (m_st[i] == 0) e_free = i;
    end
    e_rdy = 0;
    e_id = 0;
    if (i_miss_valid && e_hit >= 0) begin
      e_rdy = !(e_rfv && i_refill_ready && e_rfid == e_hit);
      e_id = e_rdy ? e_hit : 0;
    end else if (i_miss_valid && e_free >= 0) begin
      e_rdy = 1;
      e_id = e_free;
    end
    ck("miss_ready", 128'(o_miss_ready), 128'(e_rdy));
    ck("miss_id", 128'(o_miss_id), 128'(e_id));
    ck("l2_valid", 128'(o_l2_req_valid), 128'(e_l2v));
    ck("l2_tag", 128'(o_l2_req_tag), e_l2v ? 128'(e_l2id) : 128'(0));
    ck("l2_paddr", 128'(o_l2_req_paddr),
       e_l2v ? 128'({m_line[e_l2id], 4'h0}) : 128'(0));
    ck("rf_valid", 128'(o_refill_valid), 128'(e_rfv));
    ck("rf_paddr", 128'(o_refill_paddr),
       e_rfv ? 128'({m_line[e_rfid], 4'h0}) : 128'(0));
    ck("rf_data", o_refill_data, e_rfv ? m_data[e_rfid] : 128'(0));
    ck("wk_valid", 128'(o_wakeup_valid), 128'(m_wk));
    if (m_wk) ck("wk_id", 128'(o_wakeup_id), 128'(m_wk_id));
    ck("busy", 128'(o_busy_vec), 128'(busy));
  endtask

  task automatic upd();
    bit rfhs;
    if (!i_reset_n) begin
      mreset();
      return;
    end
    rfhs = e_rfv && i_refill_ready;
    if (i_l2_resp_valid && m_st[int'(i_l2_resp_tag)] == 2) begin
      m_st[int'(i_l2_resp_tag)] = 3;
      m_data[int'(i_l2_resp_tag)] = i_l2_resp_data;
    end
    if (rfhs) begin
      m_st[e_rfid] = 0;
      m_rf_ptr = (e_rfid + 1) % 2;
      m_rf_cur = -1;
    end else if (e_rfv) m_rf_cur = e_rfid;
    if (e_l2v && i_l2_req_ready) begin
      m_st[e_l2id] = 2;
      m_l2_ptr = (e_l2id + 1) % 2;
      m_l2_cur = -1;
    end else if (e_l2v) m_l2_cur = e_l2id;
    if (e_rdy && e_hit < 0) begin
      m_st[e_free] = 1;
      m_line[e_free] = i_miss_paddr[55:4];
    end
    m_wk = rfhs;
    if (rfhs) m_wk_id = e_rfid;
  endtask

  task automatic dflt();
    i_miss_valid = 0;
    i_miss_paddr = '0;
    i_l2_req_ready = 0;
    i_l2_resp_valid = 0;
    i_l2_resp_tag = '0;
    i_l2_resp_data = '0;
    i_refill_ready = 0;
  endtask

  task automatic nxt();
    @(posedge i_clk);
    upd();
    @(negedge i_clk);
    dflt();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int j;

  initial begin
    dflt();
    i_reset_n = 0;
    mreset();
    d0 = rnd128(); d1 = rnd128(); d2 = rnd128();
    @(negedge i_clk);
    chk();
    ck("rst_l2v", 128'(o_l2_req_valid), 128'(0));
    ck("rst_busy", 128'(o_busy_vec), 128'(0));
    nxt(); i_reset_n = 1; chk();

    // single miss with merge
    nxt(); i_miss_valid = 1; i_miss_paddr = 56'h8000_1234; chk();
    ck("s_rdy", 128'(o_miss_ready), 128'(1));
    ck("s_id", 128'(o_miss_id), 128'(0));
    nxt(); i_l2_req_ready = 1; chk();
    ck("s_l2v", 128'(o_l2_req_valid), 128'(1));
    ck("s_l2pa", 128'(o_l2_req_paddr), 128'(56'h8000_1230));
    nxt(); i_miss_valid = 1; i_miss_paddr = 56'h8000_123C; chk();
    ck("mg_rdy", 128'(o_miss_ready), 128'(1));
    ck("mg_busy", 128'(o_busy_vec), 128'(2'b01));
    nxt(); chk();
    ck("mg_nol2", 128'(o_l2_req_valid), 128'(0));
    nxt(); i_l2_resp_valid = 1; i_l2_resp_data = d0; chk();
    ck("s_norf", 128'(o_refill_valid), 128'(0));
    nxt(); i_refill_ready = 1; chk();
    ck("s_rfv", 128'(o_refill_valid), 128'(1));
    ck("s_rfd", o_refill_data, d0);
    ck("s_rfpa", 128'(o_refill_paddr), 128'(56'h8000_1230));
    nxt(); chk();
    ck("s_wk", 128'(o_wakeup_valid), 128'(1));
    ck("s_wkid", 128'(o_wakeup_id), 128'(0));
    ck("s_busy", 128'(o_busy_vec), 128'(0));

    // full, L2 and refill backpressure
    nxt(); i_miss_valid = 1; i_miss_paddr = 56'h1000; chk();
    ck("f_id0", 128'(o_miss_id), 128'(0));
    nxt(); i_miss_valid = 1; i_miss_paddr = 56'h2000; chk();
    ck("f_id1", 128'(o_miss_id), 128'(1));
    nxt(); i_miss_valid = 1; i_miss_paddr = 56'h3000; chk();
    ck("f_full", 128'(o_miss_ready), 128'(0));
    nxt(); i_miss_valid = 1; i_miss_paddr = 56'h2008; chk();
    ck("f_mg_rdy", 128'(o_miss_ready), 128'(1));
    ck("f_mg_id", 128'(o_miss_id), 128'(1));
    repeat (2) begin
      nxt(); chk();
      ck("bp_tag", 128'(o_l2_req_tag), 128'(0));
      ck("bp_pa", 128'(o_l2_req_paddr), 128'(56'h1000));
    end
    nxt(); i_l2_req_ready = 1; chk();
    nxt(); i_l2_req_ready = 1; chk();
    ck("bp_next", 128'(o_l2_req_tag), 128'(1));
    ck("bp_npa", 128'(o_l2_req_paddr), 128'(56'h2000));
    nxt(); i_l2_resp_valid = 1; i_l2_resp_data = d1; chk();
    nxt(); i_l2_resp_valid = 1; i_l2_resp_tag = 1;
    i_l2_resp_data = d2; chk();
    repeat (2) begin
      nxt(); chk();
      ck("rbp_data", o_refill_data, d1);
    end
    nxt(); i_refill_ready = 1; i_miss_valid = 1;
    i_miss_paddr = 56'h1004; chk();
    ck("rbp_block", 128'(o_miss_ready), 128'(0));
    nxt(); i_miss_valid = 1; i_miss_paddr = 56'h1004; chk();
    ck("rbp_retry", 128'(o_miss_ready), 128'(1));
    ck("rbp_wk", 128'(o_wakeup_valid), 128'(1));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nxt();
      i_miss_valid = 1'($urandom_range(0, 1));
      i_miss_paddr = 56'h40_0000 | (56'($urandom_range(0, 3)) << 4) |
                     56'($urandom_range(0, 15));
      i_l2_req_ready = 1'($urandom_range(0, 1));
      i_refill_ready = 1'($urandom_range(0, 1));
      j = int'($urandom_range(0, 1));
      if (m_st[j] == 2 && $urandom_range(0, 1) == 1) begin
        i_l2_resp_valid = 1;
        i_l2_resp_tag = 1'(j);
        i_l2_resp_data = rnd128();
      end
      chk();
    end

    // reset mid-operation, stale response afterwards
    nxt(); i_reset_n = 0; mreset(); chk();
    nxt(); i_reset_n = 1; i_miss_valid = 1;
    i_miss_paddr = 56'h8000_5000; chk();
    nxt(); i_l2_req_ready = 1; chk();
    nxt(); chk();
    ck("rm_busy", 128'(o_busy_vec), 128'(2'b01));
    nxt(); i_reset_n = 0; mreset(); chk();
    ck("rm_busy0", 128'(o_busy_vec), 128'(0));
    ck("rm_l2v0", 128'(o_l2_req_valid), 128'(0));
    nxt(); i_reset_n = 1; i_l2_resp_valid = 1;
    i_l2_resp_data = d2; chk();
    repeat (3) begin
      nxt(); chk();
      ck("rm_norf", 128'(o_refill_valid), 128'(0));
      ck("rm_nowk", 128'(o_wakeup_valid), 128'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
